// File: rtl/out_pass4_pkg.sv
// Shared types, config field positions and limit decode for the 4-pin output arbiter.
package out_pass4_pkg;

  // Who currently owns the external pins.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN_A = 2'd1,
    OWN_B = 2'd2
  } state_t;

  // Config frame layout: per-pin register enables at the bottom, burst limit code above.
  localparam int REG_EN_LSB = 0;
  localparam int LIMIT_LSB  = 4;
  localparam int NUM_PINS   = 4;

  // Turns the 2-bit burst limit code (1, 2, 4 or 8 beats) into the index of the
  // last beat of a burst, so the counter can be compared directly against it.
  function automatic logic [2:0] decodeLastBeat(input logic [1:0] code);
    logic [2:0] lastBeat;
    case (code)
      2'd0:    lastBeat = 3'd0;
      2'd1:    lastBeat = 3'd1;
      2'd2:    lastBeat = 3'd3;
      default: lastBeat = 3'd7;
    endcase
    return lastBeat;
  endfunction

endpackage

// File: rtl/out_pass4_pin_stage.sv
// Per-pin output stage: a capture flop plus a 2:1 mux choosing flopped or direct data.
module out_pass4_pin_stage
  import out_pass4_pkg::*;
(
  input  logic                UserCLK,
  input  logic                RST,
  input  logic [NUM_PINS-1:0] i_sel,
  input  logic [NUM_PINS-1:0] i_regEn,
  output logic [NUM_PINS-1:0] o_pin
);

  logic [NUM_PINS-1:0] r_q;

  // Capture the selected data every cycle so registered pins lag by exactly one cycle.
  always_ff @(posedge UserCLK) begin
    if (RST) begin
      r_q <= '0;
    end else begin
      r_q <= i_sel;
    end
  end

  // One mux21 per pin: register enable picks the flopped copy, otherwise pass straight through.
  for (genvar g = 0; g < NUM_PINS; g++) begin : g_mux21
    assign o_pin[g] = i_regEn[g] ? r_q[g] : i_sel[g];
  end

endmodule

// File: rtl/out_pass4_arbiter.sv
// Round-robin arbiter sharing one 4-pin external port between requesters A and B,
// with a burst limit that forces a handover when the other side is waiting.
module out_pass4_arbiter
  import out_pass4_pkg::*;
#(
  parameter int NoConfigBits = 6
) (
  input  logic                    UserCLK,
  input  logic                    RST,
  input  logic [NUM_PINS-1:0]     A_I,
  input  logic                    A_REQ,
  output logic                    A_GNT,
  input  logic [NUM_PINS-1:0]     B_I,
  input  logic                    B_REQ,
  output logic                    B_GNT,
  output logic [NUM_PINS-1:0]     O,
  output logic                    O_EN,
  input  logic [NoConfigBits-1:0] ConfigBits
);

  state_t              r_state;
  state_t              w_stateNext;
  logic [2:0]          r_beats;
  logic [2:0]          w_beatsNext;
  logic                r_lastB;
  logic                w_lastBNext;
  logic                r_enQ;
  logic                w_en;
  logic [2:0]          w_lastBeat;
  logic [NUM_PINS-1:0] w_regEn;
  logic [NUM_PINS-1:0] w_sel;

  assign w_regEn    = ConfigBits[REG_EN_LSB +: NUM_PINS];
  assign w_lastBeat = decodeLastBeat(ConfigBits[LIMIT_LSB +: 2]);

  // Next owner and beat count; the burst compare uses >= so a limit lowered mid-burst ends it at once.
  always_comb begin
    w_stateNext = r_state;
    w_beatsNext = r_beats;
    case (r_state)
      IDLE: begin
        w_beatsNext = '0;
        if (A_REQ && (!B_REQ || r_lastB)) begin
          w_stateNext = OWN_A;
        end else if (B_REQ) begin
          w_stateNext = OWN_B;
        end
      end
      OWN_A: begin
        if (!A_REQ) begin
          w_beatsNext = '0;
          w_stateNext = B_REQ ? OWN_B : IDLE;
        end else if (r_beats >= w_lastBeat) begin
          w_beatsNext = '0;
          if (B_REQ) begin
            w_stateNext = OWN_B;
          end
        end else begin
          w_beatsNext = r_beats + 3'd1;
        end
      end
      OWN_B: begin
        if (!B_REQ) begin
          w_beatsNext = '0;
          w_stateNext = A_REQ ? OWN_A : IDLE;
        end else if (r_beats >= w_lastBeat) begin
          w_beatsNext = '0;
          if (A_REQ) begin
            w_stateNext = OWN_A;
          end
        end else begin
          w_beatsNext = r_beats + 3'd1;
        end
      end
      default: begin
        w_stateNext = IDLE;
        w_beatsNext = '0;
      end
    endcase
  end

  // Remember who was granted last, but only on a fresh entry so a renewed burst keeps the same value.
  always_comb begin
    w_lastBNext = r_lastB;
    if (w_stateNext == OWN_A && r_state != OWN_A) begin
      w_lastBNext = 1'b0;
    end else if (w_stateNext == OWN_B && r_state != OWN_B) begin
      w_lastBNext = 1'b1;
    end
  end

  // Arbiter state; reset favours A on the first tie by pretending B was served last.
  always_ff @(posedge UserCLK) begin
    if (RST) begin
      r_state <= IDLE;
      r_beats <= '0;
      r_lastB <= 1'b1;
      r_enQ   <= 1'b0;
    end else begin
      r_state <= w_stateNext;
      r_beats <= w_beatsNext;
      r_lastB <= w_lastBNext;
      r_enQ   <= w_en;
    end
  end

  assign A_GNT = (r_state == OWN_A);
  assign B_GNT = (r_state == OWN_B);
  assign w_en  = A_GNT | B_GNT;

  // Steer the owner's data onto the pins; nothing is driven while idle.
  always_comb begin
    w_sel = '0;
    if (A_GNT) begin
      w_sel = A_I;
    end else if (B_GNT) begin
      w_sel = B_I;
    end
  end

  out_pass4_pin_stage u_pinStage (
    .UserCLK (UserCLK),
    .RST     (RST),
    .i_sel   (w_sel),
    .i_regEn (w_regEn),
    .o_pin   (O)
  );

  // Any registered pin moves the drive qualifier onto registered timing too.
  assign O_EN = (|w_regEn) ? r_enQ : w_en;

endmodule

// File: tb/tb_out_pass4_arbiter.sv
// Directed bench for the 4-pin output arbiter; each row drives one cycle and checks
// {A_GNT, B_GNT, O_EN, O} against a hand-computed value.
module tb_out_pass4_arbiter;

  logic       clock;
  logic       reset;
  logic [3:0] aI;
  logic       aReq;
  logic       aGnt;
  logic [3:0] bI;
  logic       bReq;
  logic       bGnt;
  logic [3:0] pinOut;
  logic       pinEn;
  logic [5:0] configBits;

  int checkCount;
  int errorCount;

  out_pass4_arbiter #(.NoConfigBits(6)) dut (
    .UserCLK    (clock),
    .RST        (reset),
    .A_I        (aI),
    .A_REQ      (aReq),
    .A_GNT      (aGnt),
    .B_I        (bI),
    .B_REQ      (bReq),
    .B_GNT      (bGnt),
    .O          (pinOut),
    .O_EN       (pinEn),
    .ConfigBits (configBits)
  );

  // 10 time-unit clock.
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Count one comparison and report it if the observed value differs.
  task automatic checkOutput(input string tag, input logic [6:0] observed, input logic [6:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s observed={gntA,gntB,en,O}=%b expected=%b", tag, observed, expected);
    end
  endtask

  // Drive one cycle's inputs just after the edge, then check outputs mid-cycle.
  task automatic applyStimulus(input string tag, input logic [5:0] cfg, input logic rst,
                               input logic areq, input logic [3:0] ai,
                               input logic breq, input logic [3:0] bi,
                               input logic [6:0] expected);
    @(posedge clock);
    #1;
    configBits = cfg;
    reset      = rst;
    aReq       = areq;
    aI         = ai;
    bReq       = breq;
    bI         = bi;
    #3;
    checkOutput(tag, {aGnt, bGnt, pinEn, pinOut}, expected);
  endtask

  // Hold reset for two edges with all requests idle.
  task automatic resetDut(input logic [5:0] cfg);
    @(posedge clock);
    #1;
    configBits = cfg;
    reset = 1'b1;
    aReq = 1'b0;
    bReq = 1'b0;
    aI = 4'h0;
    bI = 4'h0;
    @(posedge clock);
    #1;
    @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    checkCount = 0;
    errorCount = 0;
    reset = 1'b1;
    aReq = 1'b0;
    bReq = 1'b0;
    aI = 4'h0;
    bI = 4'h0;
    configBits = 6'h00;

    $display("[TB] reset then idle");
    resetDut(6'h00);
    for (int i = 0; i < 5; i++) begin
      applyStimulus($sformatf("idle c%0d", i + 1), 6'h00, 0, 0, 4'h0, 0, 4'h0, 7'b0000000);
    end

    $display("[TB] single requester, bypass pins");
    resetDut(6'h00);
    applyStimulus("bypass c1", 6'h00, 0, 1, 4'h0, 0, 4'h0, 7'b0000000);
    applyStimulus("bypass c2", 6'h00, 0, 1, 4'h1, 0, 4'h0, 7'b1010001);
    applyStimulus("bypass c3", 6'h00, 0, 1, 4'h2, 0, 4'h0, 7'b1010010);
    applyStimulus("bypass c4", 6'h00, 0, 1, 4'h3, 0, 4'h0, 7'b1010011);
    applyStimulus("bypass c5", 6'h00, 0, 0, 4'h4, 0, 4'h0, 7'b1010100);
    applyStimulus("bypass c6", 6'h00, 0, 0, 4'h0, 0, 4'h0, 7'b0000000);

    $display("[TB] single requester, registered pins");
    resetDut(6'h0F);
    applyStimulus("reg c1", 6'h0F, 0, 1, 4'h0, 0, 4'h0, 7'b0000000);
    applyStimulus("reg c2", 6'h0F, 0, 1, 4'h1, 0, 4'h0, 7'b1000000);
    applyStimulus("reg c3", 6'h0F, 0, 1, 4'h2, 0, 4'h0, 7'b1010001);
    applyStimulus("reg c4", 6'h0F, 0, 1, 4'h3, 0, 4'h0, 7'b1010010);
    applyStimulus("reg c5", 6'h0F, 0, 0, 4'h4, 0, 4'h0, 7'b1010011);
    applyStimulus("reg c6", 6'h0F, 0, 0, 4'h0, 0, 4'h0, 7'b0010100);
    applyStimulus("reg c7", 6'h0F, 0, 0, 4'h0, 0, 4'h0, 7'b0000000);

    $display("[TB] contention, limit 2");
    resetDut(6'h10);
    applyStimulus("contend c1", 6'h10, 0, 1, 4'hA, 1, 4'h5, 7'b0000000);
    applyStimulus("contend c2", 6'h10, 0, 1, 4'hA, 1, 4'h5, 7'b1011010);
    applyStimulus("contend c3", 6'h10, 0, 1, 4'hA, 1, 4'h5, 7'b1011010);
    applyStimulus("contend c4", 6'h10, 0, 1, 4'hA, 1, 4'h5, 7'b0110101);
    applyStimulus("contend c5", 6'h10, 0, 1, 4'hA, 1, 4'h5, 7'b0110101);
    applyStimulus("contend c6", 6'h10, 0, 1, 4'hA, 1, 4'h5, 7'b1011010);
    applyStimulus("contend c7", 6'h10, 0, 1, 4'hA, 1, 4'h5, 7'b1011010);
    applyStimulus("contend c8", 6'h10, 0, 1, 4'hA, 1, 4'h5, 7'b0110101);

    $display("[TB] burst renewal, limit 1");
    resetDut(6'h00);
    applyStimulus("renew c1", 6'h00, 0, 0, 4'hA, 1, 4'h5, 7'b0000000);
    for (int i = 2; i <= 6; i++) begin
      applyStimulus($sformatf("renew c%0d", i), 6'h00, 0, 0, 4'hA, 1, 4'h5, 7'b0110101);
    end
    applyStimulus("renew c7", 6'h00, 0, 0, 4'hA, 0, 4'h5, 7'b0110101);
    applyStimulus("renew c8", 6'h00, 0, 1, 4'hA, 1, 4'h5, 7'b0000000);
    applyStimulus("renew c9", 6'h00, 0, 1, 4'hA, 1, 4'h5, 7'b1011010);

    $display("[TB] release handover, limit 8");
    resetDut(6'h30);
    applyStimulus("release c1", 6'h30, 0, 1, 4'hA, 0, 4'h5, 7'b0000000);
    applyStimulus("release c2", 6'h30, 0, 1, 4'hA, 0, 4'h5, 7'b1011010);
    applyStimulus("release c3", 6'h30, 0, 0, 4'hA, 1, 4'h5, 7'b1011010);
    applyStimulus("release c4", 6'h30, 0, 0, 4'hA, 1, 4'h5, 7'b0110101);
    applyStimulus("release c5", 6'h30, 0, 0, 4'hA, 0, 4'h5, 7'b0110101);
    applyStimulus("release c6", 6'h30, 0, 0, 4'hA, 0, 4'h5, 7'b0000000);

    $display("[TB] limit lowered mid-burst");
    resetDut(6'h30);
    applyStimulus("limchg c1", 6'h30, 0, 1, 4'hA, 1, 4'h5, 7'b0000000);
    applyStimulus("limchg c2", 6'h30, 0, 1, 4'hA, 1, 4'h5, 7'b1011010);
    applyStimulus("limchg c3", 6'h30, 0, 1, 4'hA, 1, 4'h5, 7'b1011010);
    applyStimulus("limchg c4", 6'h00, 0, 1, 4'hA, 1, 4'h5, 7'b1011010);
    applyStimulus("limchg c5", 6'h00, 0, 1, 4'hA, 1, 4'h5, 7'b0110101);
    applyStimulus("limchg c6", 6'h00, 0, 1, 4'hA, 1, 4'h5, 7'b1011010);

    $display("[TB] reset mid-burst, registered pins");
    resetDut(6'h3F);
    applyStimulus("midrst c1", 6'h3F, 0, 0, 4'hA, 1, 4'h5, 7'b0000000);
    applyStimulus("midrst c2", 6'h3F, 0, 0, 4'hA, 1, 4'h5, 7'b0100000);
    applyStimulus("midrst c3", 6'h3F, 0, 0, 4'hA, 1, 4'h5, 7'b0110101);
    applyStimulus("midrst c4", 6'h3F, 1, 1, 4'hA, 1, 4'h5, 7'b0110101);
    applyStimulus("midrst c5", 6'h3F, 0, 1, 4'hA, 1, 4'h5, 7'b0000000);
    applyStimulus("midrst c6", 6'h3F, 0, 1, 4'hA, 1, 4'h5, 7'b1000000);
    applyStimulus("midrst c7", 6'h3F, 0, 1, 4'hA, 1, 4'h5, 7'b1011010);

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule

// File: doc/out_pass4_arbiter.md
# out_pass4_arbiter

Round-robin arbiter that shares one 4-pin external output port between two fabric requesters (A, B) inside the RAM_IO tile. Each pin has a config-selectable output flop/bypass: registered when its config bit is 1, combinational when it is 0. A configurable burst limit bounds how long one requester holds the pins while the other is waiting.

## Interface
Parameters:
- NoConfigBits, 6, config frame width.
  - [3:0]: per-pin register enable.
  - [5:4]: burst limit code, 0→1, 1→2, 2→4, 3→8 beats.

Ports:
- UserCLK  input  1  fabric user clock (EXTERNAL, SHARED_PORT); sole clock.
- RST  input  1  synchronous, active-high reset.
- A_I  input  4  requester A data.
- A_REQ  input  1  requester A wants the pins.
- A_GNT  output  1  A owns the pins this cycle (registered).
- B_I  input  4  requester B data.
- B_REQ  input  1  requester B wants the pins.
- B_GNT  output  1  B owns the pins this cycle (registered).
- O  output  4  external pin data (EXTERNAL).
- O_EN  output  1  external pin-drive qualifier (EXTERNAL).
- ConfigBits  input  NoConfigBits  frame config (GLOBAL).

## Operation
- States:
  - IDLE: no grant.
  - OWN_A: A_GNT=1.
  - OWN_B: B_GNT=1.
  - Exactly one state holds at any time. A_GNT and B_GNT are never both 1.
- last_served flag: updated on every entry to OWN_A/OWN_B. Reset value is B, so A wins the first tie.
- IDLE transitions:
  - One request → grant that requester.
  - Both requesting → grant the requester that is not last_served.
  - No request → stay IDLE.
- OWN_x, beat counter `beats` (3 bits):
  - Increments on each cycle with x_REQ=1.
  - x_REQ=0 (release) → go to OWN_y if y_REQ, else IDLE; clear `beats`.
  - x_REQ=1, beats==limit-1, y_REQ=1 → go to OWN_y next cycle with no idle gap; clear `beats`.
  - x_REQ=1, beats==limit-1, y_REQ=0 → stay OWN_x; clear `beats` (burst renews).
- Selected data: sel = A_I if A_GNT, else B_I if B_GNT, else 4'b0.
- Per pin i:
  - Q[i] <= sel[i] every cycle.
  - O[i] = ConfigBits[i] ? Q[i] : sel[i].
- en = A_GNT|B_GNT. en_q <= en. O_EN = (|ConfigBits[3:0]) ? en_q : en.
  - A mixed configuration is legal; O_EN then follows the registered timing.
- Limit decode is combinational from ConfigBits[5:4]. A change to the limit mid-burst takes effect on the next compare.
  - If beats ≥ new limit-1, the burst ends on the current REQ cycle.

## Timing
- Reset (RST=1 at a UserCLK edge), values after that edge:
  - state=IDLE, A_GNT=B_GNT=0, beats=0, last_served=B, Q=0, en_q=0.
  - O=0, O_EN=0.
  - A reset asserted mid-burst drops the grant at that edge; no final beat is output.
- Grant latency: REQ sampled high at edge n → GNT high from edge n+1.
- Release latency: REQ sampled low at edge n → GNT low (or handed over) from edge n+1.
  - Data on x_I in the cycle REQ drops is still driven, because GNT is still 1.
- Bypass pins: O reflects the granted x_I in the same cycle.
- Registered pins: O reflects it one cycle later.
- Handover: the last beat of x and the first beat of y are in adjacent cycles.
- Simultaneous events:
  - Both REQ rising in the same cycle from IDLE → round-robin rule.
  - Owner releasing while the other requests → immediate handover, regardless of `beats`.
- Worst-case wait for a requesting side: limit+1 cycles after its REQ is sampled.

## Structure
- Shared package out_pass4_pkg:
  - State enum (IDLE/OWN_A/OWN_B).
  - Limit-code decode function.
  - Config bit index constants (REG_EN_LSB=0, LIMIT_LSB=4).
- One sub-module, out_pass4_pin_stage: flop + cus_mux21 per pin, 4 bits wide, clocked by UserCLK, with the same RST.
- Arbiter FSM, counter and data select live in the top.

## Test plan
- Reset then idle:
  - Stimulus: RST high 2 cycles, then low; REQs 0.
  - Required: O=0, O_EN=0, both GNT=0, for 5 cycles.
- Single requester, bypass:
  - Stimulus: ConfigBits=6'b000000, A_REQ=1 for 4 cycles, A_I=1,2,3,4.
  - Required: A_GNT high on cycles 2–5. O=1..4 in those same cycles. O_EN tracks A_GNT.
- Registered path:
  - Stimulus: ConfigBits[3:0]=4'hF, same stimulus as the bypass case.
  - Required: O=1..4 delayed by one more cycle. O_EN is delayed by one more cycle.
- Contention with limit 2:
  - Stimulus: ConfigBits[5:4]=1, A_REQ and B_REQ both held high from IDLE.
  - Required: grants go A,A,B,B,A,A… with no gap.
- Burst renewal:
  - Stimulus: limit 1, only B requesting for 6 cycles.
  - Required: B_GNT continuous for 6 cycles; last_served=B afterwards.
  - Follow-up: then both requesting from IDLE → A granted first.
- Reset mid-burst:
  - Stimulus: RST asserted during OWN_B.
  - Required: B_GNT=0, O=0, O_EN=0 after that edge.
  - Follow-up: with both requesting after release, A wins.
